// File: rtl/priority_encoder.sv
// Registered priority encoder: reports the highest asserted request index and a valid flag.
// Define PRIORITY_ENCODER_ONEHOT_EN to add a registered one-hot output oh of the winning bit.
module priority_encoder #(
  parameter int WIDTH  = 4,
  parameter int CODE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  d,
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  output logic [WIDTH-1:0]  oh,
`endif
  output logic [CODE_W-1:0] y,
  output logic              v
);

  logic [CODE_W-1:0] y_d, y_q;
  logic              v_d, v_q;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  logic [WIDTH-1:0]  oh_d, oh_q;
`endif

  // Combinational encode: scanning upward lets the highest set bit overwrite lower ones.
  always_comb begin
    y_d = {CODE_W{1'b0}};
    v_d = 1'b0;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    oh_d = {WIDTH{1'b0}};
`endif
    for (int i = 0; i < WIDTH; i++) begin
      y_d = d[i] ? CODE_W'(i) : y_d;
      v_d = v_d | d[i];
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      oh_d = d[i] ? (WIDTH'(1) << i) : oh_d;
`endif
    end
  end

  // Output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= {CODE_W{1'b0}};
      v_q <= 1'b0;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      oh_q <= {WIDTH{1'b0}};
`endif
    end else begin
      y_q <= y_d;
      v_q <= v_d;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      oh_q <= oh_d;
`endif
    end
  end

  assign y = y_q;
  assign v = v_q;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  assign oh = oh_q;
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard bench for priority_encoder at WIDTH=4 and WIDTH=8 (oh checked when PRIORITY_ENCODER_ONEHOT_EN is set).
module tb_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d;
  logic [1:0] y;
  logic       v;
  logic [7:0] d8;
  logic [2:0] y8;
  logic       v8;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  logic [3:0] oh;
  logic [7:0] oh8;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] y;
    logic       v;
    logic [3:0] oh;
    logic [2:0] y8;
    logic       v8;
    logic [7:0] oh8;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  priority_encoder #(.WIDTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    .oh    (oh),
`endif
    .y     (y),
    .v     (v)
  );

  priority_encoder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d8),
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    .oh    (oh8),
`endif
    .y     (y8),
    .v     (v8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: scan from the top down, first set bit wins.
  function automatic exp_t model(input logic [3:0] di, input logic [7:0] d8i);
    exp_t e;
    e.y = 2'd0; e.v = 1'b0; e.oh = 4'd0;
    e.y8 = 3'd0; e.v8 = 1'b0; e.oh8 = 8'd0;
    for (int i = 3; i >= 0; i--) begin
      if (di[i]) begin
        e.y = i[1:0]; e.v = 1'b1; e.oh = 4'd1 << i;
        break;
      end
    end
    for (int i = 7; i >= 0; i--) begin
      if (d8i[i]) begin
        e.y8 = i[2:0]; e.v8 = 1'b1; e.oh8 = 8'd1 << i;
        break;
      end
    end
    return e;
  endfunction

  task automatic drive(input logic [3:0] di, input logic [7:0] d8i);
    d  = di;
    d8 = d8i;
    sb.push_back(model(di, d8i));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".y"}, 64'(y), 64'd0);
    check({tag, ".v"}, 64'(v), 64'd0);
    check({tag, ".y8"}, 64'(y8), 64'd0);
    check({tag, ".v8"}, 64'(v8), 64'd0);
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    check({tag, ".oh"}, 64'(oh), 64'd0);
    check({tag, ".oh8"}, 64'(oh8), 64'd0);
`endif
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".y"}, 64'(y), 64'(e.y));
      check({tag, ".v"}, 64'(v), 64'(e.v));
      check({tag, ".y8"}, 64'(y8), 64'(e.y8));
      check({tag, ".v8"}, 64'(v8), 64'(e.v8));
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      check({tag, ".oh"}, 64'(oh), 64'(e.oh));
      check({tag, ".oh8"}, 64'(oh8), 64'(e.oh8));
`endif
    end else begin
      check({tag, ".sb_empty"}, 64'd1, 64'd0);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] di, input logic [7:0] d8i);
    @(negedge clk);
    if (sb.size() > 0) compare_out(tag);
    drive(di, d8i);
  endtask

  initial begin
    rst_n = 1'b0;
    d     = 4'b1111;
    d8    = 8'hFF;
    #1;
    check_zero("rst_t0");
    repeat (3) begin
      @(negedge clk);
      check_zero("rst_hold");
    end

    // Release reset; first edge after release samples d normally.
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 8'hFF);

    for (int i = 0; i < 16; i++) begin
      logic [7:0] p;
      p = 8'(i * 37 + 3);
      if (i == 0) p = 8'd0;
      step("sweep", 4'(i), p);
    end

    step("mask", 4'b1011, 8'b0010_1100);
    step("mask", 4'b0110, 8'b0000_0111);
    step("mask", 4'b0011, 8'b1000_0001);
    step("drop", 4'b1000, 8'b1000_0000);
    step("drop", 4'b0000, 8'b0000_0000);
    step("after", 4'b0100, 8'b0100_0000);
    @(negedge clk);
    compare_out("settled");

    // Mid-run async reset between edges; in-flight sample must be discarded.
    drive(4'b0100, 8'b0100_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    sb.delete();
    @(negedge clk);
    check_zero("async_hold");
    rst_n = 1'b1;
    drive(4'b0010, 8'b0001_0000);
    @(negedge clk);
    compare_out("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
